// File: rtl/tile_match_core.sv
// Tile-matching game engine: owns the board symbols, the two-pick selection
// sequence, match/mismatch resolution, the move score and end-of-game status.
module tile_match_core #(
    parameter int NUM_TILES   = 10,
    parameter int TILE_W      = 4,
    parameter int SCORE_W     = 8,
    parameter int SHOW_CYCLES = 50000000,
    parameter int MAX_MOVES   = 0,
    parameter int IDX_W       = $clog2(NUM_TILES)
) (
    input  logic                 CLOCK_50,
    input  logic                 userquit,
    input  logic                 load_en,
    input  logic [IDX_W-1:0]     load_idx,
    input  logic [TILE_W-1:0]    load_sym,
    input  logic                 start,
    input  logic                 sel_valid,
    input  logic [IDX_W-1:0]     sel_idx,
    output logic                 sel_ready,
    output logic                 sel_err,
    output logic [NUM_TILES-1:0] revealed,
    output logic [NUM_TILES-1:0] matched,
    output logic [SCORE_W-1:0]   moves,
    output logic [IDX_W-1:0]     pairs_found,
    output logic                 in_game,
    output logic                 game_over,
    output logic                 won,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_WAIT_FIRST  = 3'd1,
        S_WAIT_SECOND = 3'd2,
        S_COMPARE     = 3'd3,
        S_SHOW        = 3'd4,
        S_DONE        = 3'd5
    } state_t;

    localparam int                 TMR_W      = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [TMR_W-1:0]   TMR_LOAD   = TMR_W'(SHOW_CYCLES - 1);
    localparam logic [IDX_W:0]     TILES_EXT  = (IDX_W + 1)'(NUM_TILES);
    localparam logic [IDX_W-1:0]   NUM_PAIRS  = IDX_W'(NUM_TILES / 2);
    localparam logic [SCORE_W-1:0] MOVE_LIMIT = SCORE_W'(MAX_MOVES);

    state_t state_q, state_d;

    logic [TILE_W-1:0]    board_q [NUM_TILES];
    logic [TILE_W-1:0]    board_d [NUM_TILES];
    logic [IDX_W-1:0]     first_q, first_d;
    logic [IDX_W-1:0]     second_q, second_d;
    logic [NUM_TILES-1:0] revealed_q, revealed_d;
    logic [NUM_TILES-1:0] matched_q, matched_d;
    logic [SCORE_W-1:0]   moves_q, moves_d;
    logic [IDX_W-1:0]     pairs_q, pairs_d;
    logic                 won_q, won_d;
    logic                 sel_err_q, sel_err_d;
    logic [TMR_W-1:0]     timer_q, timer_d;

    logic sel_in_range;
    logic sel_accept;
    logic load_ok;
    logic pair_equal;
    logic last_pair;
    logic limit_hit;
    logic restart_ok;

    // Selection qualification and compare-stage decisions
    always_comb begin
        sel_in_range = ({1'b0, sel_idx} < TILES_EXT);
        load_ok      = ({1'b0, load_idx} < TILES_EXT);
        sel_accept   = sel_valid && sel_ready && sel_in_range && !matched_q[sel_idx]
                       && !(state_q == S_WAIT_SECOND && sel_idx == first_q);
        pair_equal   = (board_q[first_q] == board_q[second_q]);
        last_pair    = ((pairs_q + IDX_W'(1)) == NUM_PAIRS);
        limit_hit    = (MAX_MOVES != 0) && (moves_q >= MOVE_LIMIT);
        restart_ok   = start && (state_q == S_IDLE || state_q == S_DONE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (userquit) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_WAIT_FIRST;
            S_WAIT_FIRST:   if (sel_accept) state_d = S_WAIT_SECOND;
            S_WAIT_SECOND:  if (sel_accept) state_d = S_COMPARE;
            S_COMPARE: begin
                if (!pair_equal)    state_d = S_SHOW;
                else if (last_pair) state_d = S_DONE;
                else                state_d = S_WAIT_FIRST;
            end
            S_SHOW: begin
                if (timer_q == '0) state_d = limit_hit ? S_DONE : S_WAIT_FIRST;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sel_ready = (state_q == S_WAIT_FIRST) || (state_q == S_WAIT_SECOND);
        in_game   = (state_q == S_WAIT_FIRST) || (state_q == S_WAIT_SECOND)
                    || (state_q == S_COMPARE) || (state_q == S_SHOW);
        game_over = (state_q == S_DONE);
        state     = state_q;
    end

    always_comb begin
        board_d    = board_q;
        first_d    = first_q;
        second_d   = second_q;
        revealed_d = revealed_q;
        matched_d  = matched_q;
        moves_d    = moves_q;
        pairs_d    = pairs_q;
        won_d      = won_q;
        timer_d    = timer_q;
        sel_err_d  = sel_valid && sel_ready && !sel_accept;

        if (state_q == S_IDLE && load_en && load_ok) begin
            board_d[load_idx] = load_sym;
        end

        if (restart_ok) begin
            revealed_d = '0;
            matched_d  = '0;
            moves_d    = '0;
            pairs_d    = '0;
            won_d      = 1'b0;
        end

        case (state_q)
            S_WAIT_FIRST: begin
                if (sel_accept) begin
                    first_d             = sel_idx;
                    revealed_d[sel_idx] = 1'b1;
                end
            end
            S_WAIT_SECOND: begin
                if (sel_accept) begin
                    second_d            = sel_idx;
                    revealed_d[sel_idx] = 1'b1;
                    if (moves_q != '1) moves_d = moves_q + SCORE_W'(1);
                end
            end
            S_COMPARE: begin
                // revealed holds exactly the two picks, so it doubles as the pair mask
                if (pair_equal) begin
                    matched_d  = matched_q | revealed_q;
                    revealed_d = '0;
                    pairs_d    = pairs_q + IDX_W'(1);
                    if (last_pair) won_d = 1'b1;
                end else begin
                    timer_d = TMR_LOAD;
                end
            end
            S_SHOW: begin
                if (timer_q == '0) revealed_d = '0;
                else               timer_d    = timer_q - TMR_W'(1);
            end
            default: ;
        endcase
    end

    // Board contents survive userquit so a quit does not force a reload
    always_ff @(posedge CLOCK_50) begin
        board_q  <= board_d;
        first_q  <= first_d;
        second_q <= second_d;
    end

    always_ff @(posedge CLOCK_50) begin
        if (userquit) begin
            revealed_q <= '0;
            matched_q  <= '0;
            moves_q    <= '0;
            pairs_q    <= '0;
            won_q      <= 1'b0;
            sel_err_q  <= 1'b0;
            timer_q    <= '0;
        end else begin
            revealed_q <= revealed_d;
            matched_q  <= matched_d;
            moves_q    <= moves_d;
            pairs_q    <= pairs_d;
            won_q      <= won_d;
            sel_err_q  <= sel_err_d;
            timer_q    <= timer_d;
        end
    end

    assign revealed    = revealed_q;
    assign matched     = matched_q;
    assign moves       = moves_q;
    assign pairs_found = pairs_q;
    assign won         = won_q;
    assign sel_err     = sel_err_q;

endmodule
